// File: rtl/fifo_arb_pkg.sv
// Shared types, default parameters and width helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned NumReqDef      = 4;
  localparam int unsigned DataWDef       = 8;
  localparam int unsigned BurstLenDef    = 16;
  localparam int unsigned CntWDef        = 8;
  localparam int unsigned SpaceThreshDef = 224;

  typedef enum logic [1:0] {
    StRstWait,
    StIdle,
    StBurst
  } arb_state_e;

  // Ceiling log2, never below 1 so index/counter vectors always have a bit.
  function automatic int unsigned log2c(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating-priority picker: first set request searching upward from rr_ptr, with wrap.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDef,
  parameter int unsigned PTR_W   = log2c(NumReqDef)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               found,
  output logic [PTR_W-1:0]   winner
);

  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(rr_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ producers.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = NumReqDef,
  parameter int unsigned DATA_W       = DataWDef,
  parameter int unsigned BURST_LEN    = BurstLenDef,
  parameter int unsigned CNT_W        = CntWDef,
  parameter int unsigned SPACE_THRESH = SpaceThreshDef
) (
  input  logic                      wr_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  input  logic                      full,
  input  logic                      almost_full,
  input  logic                      wr_rst_busy,
  input  logic [CNT_W-1:0]          wr_data_count,
  output logic                      burst_done,
  output logic                      burst_abort,
  output logic                      ovf_err
);

  localparam int unsigned PtrW  = log2c(NUM_REQ);
  localparam int unsigned BeatW = log2c(BURST_LEN);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PtrW-1:0]     gidx_q, gidx_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BeatW-1:0]    beat_cnt_q, beat_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;
  logic                ovf_q, ovf_d;

  logic                pick_found;
  logic [PtrW-1:0]     pick_idx;
  logic [PtrW-1:0]     ptr_after;
  logic                space_ok;
  logic                accept;
  logic                beat_end;

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .winner (pick_idx)
  );

  assign space_ok  = 32'(wr_data_count) <= SPACE_THRESH;
  assign ptr_after = (gidx_q == PtrW'(NUM_REQ - 1)) ? '0 : gidx_q + PtrW'(1);
  assign accept    = (state_q == StBurst) & req_valid[gidx_q] & req_ready[gidx_q];
  assign beat_end  = accept & (req_last[gidx_q] | (beat_cnt_q == BeatW'(BURST_LEN - 1)));

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRstWait;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    wr_en_d    = accept;
    wr_data_d  = accept ? req_data[gidx_q*DATA_W +: DATA_W] : wr_data_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    ovf_d      = ovf_q | (wr_en_q & full);
    unique case (state_q)
      StRstWait: begin
        if (!wr_rst_busy) state_d = StIdle;
      end
      StIdle: begin
        if (!wr_rst_busy && pick_found && space_ok) begin
          state_d    = StBurst;
          grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          gidx_d     = pick_idx;
          beat_cnt_d = '0;
        end
      end
      StBurst: begin
        // Busy cannot coincide with an accepted beat: ready is gated by it.
        if (wr_rst_busy) begin
          state_d  = StRstWait;
          grant_d  = '0;
          abort_d  = 1'b1;
          rr_ptr_d = ptr_after;
        end else begin
          if (accept) beat_cnt_d = beat_cnt_q + BeatW'(1);
          if (beat_end) begin
            state_d  = StIdle;
            grant_d  = '0;
            done_d   = 1'b1;
            rr_ptr_d = ptr_after;
          end
        end
      end
      default: state_d = StRstWait;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StBurst) req_ready[gidx_q] = ~almost_full & ~full & ~wr_rst_busy;
  end

  assign grant        = grant_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign burst_done   = done_q;
  assign burst_abort  = abort_q;
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed plus randomized bench for fifo_wr_arb against a turn-based reference model.
module tb_fifo_wr_arb;

  localparam int NUM_REQ      = 4;
  localparam int DATA_W       = 8;
  localparam int BURST_LEN    = 16;
  localparam int CNT_W        = 8;
  localparam int SPACE_THRESH = 224;

  logic                      wr_clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req, req_valid, req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready, grant;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic                      full, almost_full, wr_rst_busy;
  logic [CNT_W-1:0]          wr_data_count;
  logic                      burst_done, burst_abort, ovf_err;

  fifo_wr_arb #(
    .NUM_REQ      (NUM_REQ),
    .DATA_W       (DATA_W),
    .BURST_LEN    (BURST_LEN),
    .CNT_W        (CNT_W),
    .SPACE_THRESH (SPACE_THRESH)
  ) dut (
    .wr_clk        (wr_clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .grant         (grant),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .full          (full),
    .almost_full   (almost_full),
    .wr_rst_busy   (wr_rst_busy),
    .wr_data_count (wr_data_count),
    .burst_done    (burst_done),
    .burst_abort   (burst_abort),
    .ovf_err       (ovf_err)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_chk, n_pass, n_fail;

  // Reference model: who owns the port, how many beats they have sent, whose turn is next.
  int          m_owner, m_beats, m_next;
  bit          m_wait;
  bit          m_wr_en, m_done, m_abort, m_ovf;
  logic [7:0]  m_wr_data;

  // Observation bookkeeping for the directed scenarios.
  int          wrs;
  int          q_done_len[$];
  int          q_abort_len[$];
  int          q_onset[$];
  logic [3:0]  prev_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1; m_beats = 0; m_next = 0; m_wait = 1'b1;
    m_wr_en = 1'b0; m_done = 1'b0; m_abort = 1'b0; m_ovf = 1'b0; m_wr_data = '0;
  endfunction

  function automatic logic [3:0] exp_ready();
    if (m_owner >= 0 && !almost_full && !full && !wr_rst_busy) return 4'(1) << m_owner;
    return 4'b0;
  endfunction

  function automatic void model_clock();
    int o;
    m_ovf   = m_ovf | (m_wr_en & full);
    m_wr_en = 1'b0; m_done = 1'b0; m_abort = 1'b0;
    if (m_wait) begin
      if (!wr_rst_busy) m_wait = 1'b0;
    end else if (m_owner < 0) begin
      if (!wr_rst_busy && req != 0 && wr_data_count <= SPACE_THRESH) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          o = (m_next + k) % NUM_REQ;
          if (req[o]) begin m_owner = o; break; end
        end
        m_beats = 0;
      end
    end else begin
      o = m_owner;
      if (wr_rst_busy) begin
        m_abort = 1'b1; m_next = (o + 1) % NUM_REQ; m_owner = -1; m_wait = 1'b1;
      end else if (req_valid[o] && !almost_full && !full) begin
        m_wr_en = 1'b1;
        m_wr_data = req_data[o*DATA_W +: DATA_W];
        m_beats++;
        if (req_last[o] || m_beats == BURST_LEN) begin
          m_done = 1'b1; m_next = (o + 1) % NUM_REQ; m_owner = -1;
        end
      end
    end
  endfunction

  // One clock: inputs were set just after a negedge; returns at the next negedge.
  task automatic step();
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready()));
    model_clock();
    @(posedge wr_clk);
    #1;
    chk("grant", 32'(grant), (m_owner < 0) ? 32'd0 : 32'(4'(1) << m_owner));
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(m_wr_en));
    chk("fifo_wr_data", 32'(fifo_wr_data), 32'(m_wr_data));
    chk("burst_done", 32'(burst_done), 32'(m_done));
    chk("burst_abort", 32'(burst_abort), 32'(m_abort));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    if (fifo_wr_en) wrs++;
    if (burst_done) begin q_done_len.push_back(wrs); wrs = 0; end
    if (burst_abort) begin q_abort_len.push_back(wrs); wrs = 0; end
    if (grant != 0 && prev_grant == 0)
      for (int i = 0; i < NUM_REQ; i++) if (grant[i]) q_onset.push_back(i);
    prev_grant = grant;
    @(negedge wr_clk);
  endtask

  function automatic logic [31:0] pack_onsets(input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = (v << 4) | ((i < q_onset.size()) ? 32'(q_onset[i]) : 32'hf);
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cnt5, bad16, stall_left;
    bit stalled;
    n_chk = 0; n_pass = 0; n_fail = 0; wrs = 0; prev_grant = '0;
    req = '0; req_valid = '0; req_last = '0; req_data = '0;
    full = 1'b0; almost_full = 1'b0; wr_rst_busy = 1'b1; wr_data_count = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge wr_clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("rst_flags", {29'd0, burst_done, burst_abort, ovf_err}, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // 1: release reset with busy high, then latency to first grant.
    model_reset();
    rst_n = 1'b1;
    req = 4'b0001;
    repeat (20) step();
    wr_rst_busy = 1'b0;
    n = 0;
    while (grant != 4'b0001 && n < 10) begin step(); n++; end
    chk("t1_grant_latency", 32'(n), 32'd2);

    // 2: all requesting, full-length bursts rotate 0,1,2,3,0.
    req = 4'b1111; req_valid = 4'b1111; req_data = {8'd3, 8'd2, 8'd1, 8'd0};
    repeat (85) step();
    chk("t2_grant_order", pack_onsets(5), 32'h01230);
    bad16 = 0;
    foreach (q_done_len[i]) if (q_done_len[i] != 16) bad16++;
    chk("t2_burst_lengths", 32'(bad16), 32'd0);
    chk("t2_done_count", 32'(q_done_len.size() >= 4), 32'd1);

    // 3: source 2 ends early on its 5th beat; next grant goes to 3.
    q_onset.delete(); q_done_len.delete();
    for (int c = 0; c < 60; c++) begin
      req_last = (m_owner == 2 && m_beats == 4) ? 4'b0100 : 4'b0000;
      step();
    end
    req_last = '0;
    chk("t3_onsets", pack_onsets(2), 32'h23);
    cnt5 = 0;
    foreach (q_done_len[i]) if (q_done_len[i] == 5) cnt5++;
    chk("t3_short_burst", 32'(cnt5), 32'd1);

    // 4: almost_full stall from beat 8 for 10 cycles.
    q_done_len.delete();
    stall_left = 0; stalled = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (m_owner >= 0 && m_beats == 8 && !stalled) begin stall_left = 10; stalled = 1'b1; end
      almost_full = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      step();
    end
    almost_full = 1'b0;
    bad16 = 0;
    foreach (q_done_len[i]) if (q_done_len[i] != 16) bad16++;
    chk("t4_burst_lengths", 32'(bad16), 32'd0);
    chk("t4_stall_seen", 32'(stalled), 32'd1);
    chk("t4_ovf", 32'(ovf_err), 32'd0);

    // 5: space gating at the threshold boundary.
    req = '0;
    n = 0;
    while (m_owner >= 0 && n < 40) begin step(); n++; end
    chk("t5_drain", 32'(m_owner < 0), 32'd1);
    step();
    req = 4'b0010; wr_data_count = 8'd230;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t5_gated", 32'(grant), 32'd0);
    end
    wr_data_count = 8'd224;
    step();
    chk("t5_grant_at_thresh", 32'(grant), 32'b0010);

    // 6: abort after 4 beats of source 1, then turn passes to 2.
    req = 4'b1111;
    q_abort_len.delete();
    n = 0;
    while (!burst_abort && n < 30) begin
      if (m_owner == 1 && m_beats == 4) wr_rst_busy = 1'b1;
      step();
      n++;
    end
    chk("t6_abort_seen", 32'(burst_abort), 32'd1);
    chk("t6_abort_writes", (q_abort_len.size() > 0) ? 32'(q_abort_len[0]) : 32'hffff, 32'd4);
    chk("t6_grant_cleared", 32'(grant), 32'd0);
    repeat (3) step();
    wr_rst_busy = 1'b0;
    n = 0;
    while (grant == 0 && n < 10) begin step(); n++; end
    chk("t6_next_grant", 32'(grant), 32'b0100);

    // Randomized traffic with occasional mid-run asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 350) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_grant", 32'(grant), 32'd0);
        chk("async_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("async_rst_ovf", 32'(ovf_err), 32'd0);
        model_reset();
        @(posedge wr_clk);
        @(negedge wr_clk);
        rst_n = 1'b1;
      end
      req = 4'($urandom);
      for (int i = 0; i < NUM_REQ; i++) begin
        req_valid[i] = ($urandom_range(99) < 80);
        req_last[i]  = ($urandom_range(99) < 10);
      end
      req_data      = $urandom;
      almost_full   = ($urandom_range(99) < 15);
      full          = ($urandom_range(99) < 5);
      wr_rst_busy   = ($urandom_range(99) < 2);
      wr_data_count = 8'($urandom_range(255, 200));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
